// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: waits for a host start-low, then answers with the
// response preamble and a 40-bit humidity/temperature frame on an open-drain line.
module dht11_responder #(
  parameter int unsigned CLKS_PER_US  = 100,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned ACK_DELAY_US = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_in,
  output logic       line_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  output logic       busy,
  output logic       frame_done,
  output logic       error
);

  localparam int unsigned CycW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_US - 1);
  localparam logic [15:0] StartMin = 16'(START_MIN_US);
  localparam logic [15:0] AckDelay = 16'(ACK_DELAY_US);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StHostLow  = 3'd1;
  localparam logic [2:0] StAckWait  = 3'd2;
  localparam logic [2:0] StRespLow  = 3'd3;
  localparam logic [2:0] StRespHigh = 3'd4;
  localparam logic [2:0] StBitLow   = 3'd5;
  localparam logic [2:0] StBitHigh  = 3'd6;
  localparam logic [2:0] StEndLow   = 3'd7;

  logic            line_s1_q, line_s2_q;
  logic [2:0]      state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [15:0]     us_q, us_d;
  logic [39:0]     sh_q, sh_d;
  logic [5:0]      bit_q, bit_d;
  logic            low_q, low_d;
  logic            oe_q, oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic        tick;
  logic        watch;
  logic        phase_end;
  logic [15:0] dur;
  logic [7:0]  parity;

  assign tick   = (cyc_q == CycLast);
  assign parity = hum_int + hum_float + temp_int + temp_float;
  assign watch  = (state_q == StAckWait) || (state_q == StRespHigh) || (state_q == StBitHigh);

  always_comb begin
    dur = 16'd50;
    case (state_q)
      StAckWait:              dur = AckDelay;
      StRespLow, StRespHigh:  dur = 16'd80;
      StBitHigh:              dur = sh_q[39] ? 16'd70 : 16'd26;
      default:                dur = 16'd50;
    endcase
  end

  assign phase_end = tick && (us_q == dur - 16'd1);

  always_comb begin
    state_d = state_q;
    us_d    = us_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    low_d   = low_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        us_d  = '0;
        bit_d = '0;
        if (!line_s2_q) state_d = StHostLow;
      end
      StHostLow: begin
        if (line_s2_q) begin
          if (us_q >= StartMin) begin
            state_d = StAckWait;
            sh_d    = {hum_int, hum_float, temp_int, temp_float, parity};
          end else begin
            state_d = StIdle;
          end
        end else if (tick && (us_q < StartMin)) begin
          us_d = us_q + 16'd1;
        end
      end
      default: begin
        if (phase_end) begin
          case (state_q)
            StAckWait:  state_d = StRespLow;
            StRespLow:  state_d = StRespHigh;
            StRespHigh: state_d = StBitLow;
            StBitLow:   state_d = StBitHigh;
            StBitHigh: begin
              sh_d    = {sh_q[38:0], 1'b0};
              bit_d   = bit_q + 6'd1;
              state_d = (bit_q == 6'd39) ? StEndLow : StBitLow;
            end
            default: begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          endcase
        end else if (tick) begin
          us_d = us_q + 16'd1;
        end
        // Another driver pulling low while we are released: abort the frame.
        if (watch && tick) begin
          if (!line_s2_q) begin
            if (low_q) begin
              state_d = StIdle;
              err_d   = 1'b1;
              done_d  = 1'b0;
            end else begin
              low_d = 1'b1;
            end
          end else begin
            low_d = 1'b0;
          end
        end
      end
    endcase

    if (state_d != state_q) begin
      us_d  = '0;
      low_d = 1'b0;
    end
  end

  always_comb begin
    cyc_d = cyc_q + CycW'(1);
    if ((state_d != state_q) || tick) cyc_d = '0;
  end

  assign oe_d = (state_d == StRespLow) || (state_d == StBitLow) || (state_d == StEndLow);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_s1_q <= 1'b1;
      line_s2_q <= 1'b1;
      state_q   <= StIdle;
      cyc_q     <= '0;
      us_q      <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      low_q     <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      line_s1_q <= line_in;
      line_s2_q <= line_s1_q;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      us_q      <= us_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      low_q     <= low_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign line_oe    = oe_q;
  assign frame_done = done_q;
  assign error      = err_q;
  assign busy       = (state_q != StIdle) && (state_q != StHostLow);

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: plays the host on a pulled-up wire and decodes
// the response from measured line segment lengths.
module tb_dht11_responder;

  localparam int C   = 2;
  localparam int US  = C * 10;
  localparam int MIN = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_low;
  logic       line_in;
  logic       line_oe;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic       busy, frame_done, error;

  int tests_run = 0;
  int tests_failed = 0;
  int oe_rise = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  int busy_seen = 0;
  logic oe_prev = 1'b0;
  int seg_q[$];
  longint last_t = 0;

  dht11_responder #(
    .CLKS_PER_US (C),
    .START_MIN_US(MIN),
    .ACK_DELAY_US(30)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .line_in   (line_in),
    .line_oe   (line_oe),
    .hum_int   (hum_int),
    .hum_float (hum_float),
    .temp_int  (temp_int),
    .temp_float(temp_float),
    .busy      (busy),
    .frame_done(frame_done),
    .error     (error)
  );

  assign line_in = ~(line_oe | host_low);

  always #5 clk = ~clk;

  always @(line_in) begin
    seg_q.push_back(int'($time - last_t));
    last_t = $time;
  end

  always @(negedge clk) begin
    if (line_oe && !oe_prev) oe_rise++;
    oe_prev = line_oe;
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_payload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d);
    hum_int = a; hum_float = b; temp_int = c; temp_float = d;
  endtask

  task automatic start_frame(input int host_us);
    @(negedge clk);
    oe_rise = 0; fd_cnt = 0; err_cnt = 0; busy_seen = 0;
    host_low = 1'b1;
    #1 seg_q.delete();
    repeat (host_us * C) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_rise(input int n, input int budget);
    for (int i = 0; i < budget && oe_rise < n; i++) @(negedge clk);
    check("wait_rise", oe_rise, n);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0 && err_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp);
    logic [39:0] bits;
    int bad_low, bad_high, hb;
    bits = '0; bad_low = 0; bad_high = 0;
    check({tag, "_done"}, fd_cnt, 1);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_nseg"}, seg_q.size(), 85);
    if (seg_q.size() == 85) begin
      check({tag, "_ack"}, (seg_q[1] >= 30 * US && seg_q[1] <= 32 * US), 1);
      check({tag, "_resp_low"}, seg_q[2], 80 * US);
      check({tag, "_resp_high"}, seg_q[3], 80 * US);
      for (int i = 0; i < 40; i++) begin
        if (seg_q[4 + 2 * i] != 50 * US) bad_low++;
        hb = (seg_q[5 + 2 * i] > 48 * US) ? 1 : 0;
        bits[39 - i] = hb[0];
        if (seg_q[5 + 2 * i] != (hb != 0 ? 70 : 26) * US) bad_high++;
      end
      check({tag, "_bits"}, bits, exp);
      check({tag, "_bit_low_len"}, bad_low, 0);
      check({tag, "_bit_high_len"}, bad_high, 0);
      check({tag, "_end_low"}, seg_q[84], 50 * US);
    end
    check({tag, "_busy_seen"}, busy_seen, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_oe_end"}, line_oe, 0);
  endtask

  initial begin
    reset = 1'b0;
    host_low = 1'b0;
    set_payload(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_oe", line_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", error, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    set_payload(8'h37, 8'h00, 8'h19, 8'h05);
    start_frame(60);
    wait_end(12000);
    check_frame("basic", 40'h37_00_19_05_55);

    start_frame(20);
    repeat (200 * C) @(negedge clk);
    check("short_oe", oe_rise, 0);
    check("short_busy", busy_seen, 0);
    check("short_done", fd_cnt, 0);
    check("short_err", err_cnt, 0);

    set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start_frame(60);
    wait_end(12000);
    check_frame("ff", 40'hFF_FF_FF_FF_FC);
    if (seg_q.size() == 85) begin
      check("ff_bit37_high", seg_q[79], 70 * US);
      check("ff_bit38_high", seg_q[81], 26 * US);
      check("ff_bit39_high", seg_q[83], 26 * US);
    end

    set_payload(8'h11, 8'h22, 8'h33, 8'h44);
    start_frame(60);
    wait_rise(1, 200 * C);
    for (int i = 0; i < 200 * C && line_oe; i++) @(negedge clk);
    repeat (10 * C) @(negedge clk);
    host_low = 1'b1;
    repeat (5 * C) @(negedge clk);
    host_low = 1'b0;
    repeat (20 * C) @(negedge clk);
    check("coll_err", err_cnt, 1);
    check("coll_done", fd_cnt, 0);
    check("coll_oe", line_oe, 0);
    check("coll_busy", busy, 0);

    set_payload(8'h12, 8'h34, 8'h56, 8'h78);
    start_frame(60);
    wait_rise(7, 2000);
    set_payload(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    wait_end(12000);
    check_frame("latch", 40'h12_34_56_78_14);

    set_payload(8'h01, 8'h02, 8'h03, 8'h04);
    start_frame(60);
    wait_rise(22, 8000);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_oe", line_oe, 0);
    check("midrst_busy", busy, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_done", fd_cnt, 0);
    check("midrst_idle_oe", line_oe, 0);
    start_frame(60);
    wait_end(12000);
    check_frame("after_rst", 40'h01_02_03_04_0A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
